// File: rtl/alu_execute_controller.sv
// -----------------------------------------------------------------------------
// alu_execute_controller
//
// Multi-cycle execute stage that sits in front of an external n-bit ALU. It
// owns the 8-entry general register file. Each instruction is accepted with a
// valid/ready handshake and then steps through IDLE -> LOAD -> EXEC -> WRITE.
//
// Stage registers:
//   *_p0 : instruction fields latched at the handshake (IDLE)
//   *_p1 : operand registers A/B loaded from the register file (LOAD)
//   *_p2 : result register G and carry Cs captured from the ALU (EXEC)
// The WRITE cycle writes G back, updates the flags and pulses done.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   ins_valid/ins_ready instruction handshake (ready only in IDLE)
//   ins_op/rx/ry        opcode, destination/first source, second source
//   ins_imm_sel/ins_imm second operand select and immediate value
//   alu_x/alu_y         ALU operands (A and B registers)
//   alu_cin/alu_add_sub ALU carry-in and add/subtract control
//   alu_op              ALU function select (00 add/sub, 01 and)
//   alu_result/alu_cout ALU result and carry-out
//   done                one-cycle pulse in the WRITE cycle
//   flag_z/c/n          zero, carry and negative flags
//   rd_addr/rd_data     combinational debug read port of the register file
// -----------------------------------------------------------------------------
module alu_execute_controller #(
    parameter int n = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ins_valid,
    output logic         ins_ready,
    input  logic [2:0]   ins_op,
    input  logic [2:0]   ins_rx,
    input  logic [2:0]   ins_ry,
    input  logic         ins_imm_sel,
    input  logic [n-1:0] ins_imm,
    output logic [n-1:0] alu_x,
    output logic [n-1:0] alu_y,
    output logic         alu_cin,
    output logic         alu_add_sub,
    output logic [1:0]   alu_op,
    input  logic [n-1:0] alu_result,
    input  logic         alu_cout,
    output logic         done,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_n,
    input  logic [2:0]   rd_addr,
    output logic [n-1:0] rd_data
);

    localparam int H = n / 2;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t       state;

    logic [n-1:0] regs [8];

    logic [2:0]   op_p0;
    logic [2:0]   rx_p0;
    logic [2:0]   ry_p0;
    logic         imm_sel_p0;
    logic [n-1:0] imm_p0;

    logic [n-1:0] a_p1;
    logic [n-1:0] b_p1;

    logic [n-1:0] g_p2;
    logic         cs_p2;

    // mvt result: low half of B becomes the top half, low half of A stays low.
    function automatic logic [n-1:0] pack_low_halves(input logic [n-1:0] hi_src,
                                                     input logic [n-1:0] lo_src);
        return {hi_src[H-1:0], lo_src[H-1:0]};
    endfunction

    // Opcodes whose result comes from the ALU.
    function automatic logic uses_alu(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_CMP);
    endfunction

    // Opcodes that update Z, N and C together.
    function automatic logic sets_all_flags(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

    // Opcodes that write G back into R[rx]; cmp and nop leave the file alone.
    function automatic logic writes_back(input logic [2:0] op);
        return (op == OP_MV) || (op == OP_MVT) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_AND);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ins_ready  <= 1'b1;
            done       <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_n     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            op_p0      <= '0;
            rx_p0      <= '0;
            ry_p0      <= '0;
            imm_sel_p0 <= 1'b0;
            imm_p0     <= '0;
            a_p1       <= '0;
            b_p1       <= '0;
            g_p2       <= '0;
            cs_p2      <= 1'b0;
        end else begin
            case (state)
                // ---- IDLE: accept and latch the instruction fields ----
                IDLE: begin
                    if (ins_valid) begin
                        op_p0      <= ins_op;
                        rx_p0      <= ins_rx;
                        ry_p0      <= ins_ry;
                        imm_sel_p0 <= ins_imm_sel;
                        imm_p0     <= ins_imm;
                        ins_ready  <= 1'b0;
                        state      <= LOAD;
                    end
                end
                // ---- LOAD: fetch operands into A and B ----
                LOAD: begin
                    a_p1  <= regs[rx_p0];
                    b_p1  <= imm_sel_p0 ? imm_p0 : regs[ry_p0];
                    state <= EXEC;
                end
                // ---- EXEC: capture the result into G ----
                EXEC: begin
                    if (uses_alu(op_p0)) begin
                        g_p2  <= alu_result;
                        cs_p2 <= alu_cout;
                    end else if (op_p0 == OP_MV) begin
                        g_p2 <= b_p1;
                    end else if (op_p0 == OP_MVT) begin
                        g_p2 <= pack_low_halves(b_p1, a_p1);
                    end
                    done  <= 1'b1;
                    state <= WRITE;
                end
                // ---- WRITE: write back, update flags, return to IDLE ----
                WRITE: begin
                    if (writes_back(op_p0)) begin
                        regs[rx_p0] <= g_p2;
                    end
                    if (sets_all_flags(op_p0)) begin
                        flag_z <= (g_p2 == '0);
                        flag_n <= g_p2[n-1];
                        flag_c <= cs_p2;
                    end else if (op_p0 == OP_AND) begin
                        flag_z <= (g_p2 == '0);
                        flag_n <= g_p2[n-1];
                    end
                    done      <= 1'b0;
                    ins_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ALU control follows the latched opcode once an instruction is in
    // flight; in IDLE and for non-ALU opcodes it defaults to a plain add.
    always_comb begin
        alu_op      = 2'b00;
        alu_add_sub = 1'b0;
        alu_cin     = 1'b0;
        if (state != IDLE) begin
            case (op_p0)
                OP_SUB, OP_CMP: begin
                    alu_add_sub = 1'b1;
                    alu_cin     = 1'b1;
                end
                OP_AND: begin
                    alu_op = 2'b01;
                end
                default: begin
                    alu_op = 2'b00;
                end
            endcase
        end
    end

    assign alu_x   = a_p1;
    assign alu_y   = b_p1;
    assign rd_data = regs[rd_addr];

endmodule

// File: tb/tb_alu_execute_controller.sv
module tb_alu_execute_controller;

    localparam int N = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         ins_valid;
    logic         ins_ready;
    logic [2:0]   ins_op;
    logic [2:0]   ins_rx;
    logic [2:0]   ins_ry;
    logic         ins_imm_sel;
    logic [N-1:0] ins_imm;
    logic [N-1:0] alu_x;
    logic [N-1:0] alu_y;
    logic         alu_cin;
    logic         alu_add_sub;
    logic [1:0]   alu_op;
    logic [N-1:0] alu_result;
    logic         alu_cout;
    logic         done;
    logic         flag_z;
    logic         flag_c;
    logic         flag_n;
    logic [2:0]   rd_addr;
    logic [N-1:0] rd_data;

    alu_execute_controller #(.n(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_op      (ins_op),
        .ins_rx      (ins_rx),
        .ins_ry      (ins_ry),
        .ins_imm_sel (ins_imm_sel),
        .ins_imm     (ins_imm),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_cin     (alu_cin),
        .alu_add_sub (alu_add_sub),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_cout    (alu_cout),
        .done        (done),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .flag_n      (flag_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clock = ~clock;

    // External ALU: op 01 is bitwise and, otherwise x + (y or ~y) + cin.
    logic [N:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        if (alu_op == 2'b01) begin
            alu_result = alu_x & alu_y;
            alu_cout   = 1'b0;
        end else begin
            alu_sum    = {1'b0, alu_x} + {1'b0, (alu_add_sub ? ~alu_y : alu_y)} + {{N{1'b0}}, alu_cin};
            alu_result = alu_sum[N-1:0];
            alu_cout   = alu_sum[N];
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct {
        logic [2:0]   rx;
        bit           wr;
        logic [N-1:0] old_v;
        logic [N-1:0] new_v;
        bit           z;
        bit           c;
        bit           nf;
        int           hs;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: architectural state only.
    logic [N-1:0] mr[8];
    bit mz, mc, mn;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mr[i] = '0;
        mz = 0; mc = 0; mn = 0;
    endtask

    task automatic model_exec(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                              input bit isel, input logic [N-1:0] imm, output exp_t e);
        logic [N-1:0] a, b, res;
        int ai, bi, s;
        a  = mr[rx];
        b  = isel ? imm : mr[ry];
        ai = int'(a);
        bi = int'(b);
        e.rx = rx; e.old_v = a; e.new_v = a; e.wr = 0; e.hs = cyc;
        case (op)
            3'd0: begin e.wr = 1; e.new_v = b; end
            3'd1: begin e.wr = 1; e.new_v = {b[N/2-1:0], a[N/2-1:0]}; end
            3'd2: begin
                s = ai + bi;
                res = N'(s % (1 << N));
                mc = (s >= (1 << N)); mz = (res == 0); mn = (int'(res) >= (1 << (N-1)));
                e.wr = 1; e.new_v = res;
            end
            3'd3, 3'd5: begin
                s = (ai - bi + (1 << N)) % (1 << N);
                res = N'(s);
                mc = (ai >= bi); mz = (res == 0); mn = (int'(res) >= (1 << (N-1)));
                if (op == 3'd3) begin e.wr = 1; e.new_v = res; end
            end
            3'd4: begin
                res = a & b;
                mz = (res == 0); mn = (int'(res) >= (1 << (N-1)));
                e.wr = 1; e.new_v = res;
            end
            default: ;
        endcase
        if (e.wr) mr[rx] = e.new_v;
        e.z = mz; e.c = mc; e.nf = mn;
    endtask

    // Debug-port sharing: the monitor owns it while instructions are in flight.
    logic       drv_sel = 1'b0;
    logic [2:0] drv_addr = '0;
    logic [2:0] mon_addr = '0;
    assign rd_addr = drv_sel ? drv_addr : mon_addr;

    // Monitor: pops on done, checks latency and the pre-write value, then
    // checks the written value and flags in the following cycle.
    bit   pending_post = 0;
    exp_t post;
    always @(negedge clock) begin
        if (reset) begin
            pending_post = 0;
        end else begin
            if (pending_post) begin
                chk("post_reg", 32'(rd_data), 32'(post.wr ? post.new_v : post.old_v));
                chk("post_flags", {29'd0, flag_z, flag_c, flag_n}, {29'd0, post.z, post.c, post.nf});
                pending_post = 0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    post = exp_q.pop_front();
                    chk("latency", 32'(cyc - post.hs), 32'd3);
                    chk("old_during_write", 32'(rd_data), 32'(post.old_v));
                    pending_post = 1;
                end
            end
        end
        if (pending_post) mon_addr = post.rx;
        else if (exp_q.size() != 0) mon_addr = exp_q[0].rx;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                         input bit isel, input logic [N-1:0] imm, input bit hold, input bit push);
        exp_t e;
        int guard = 0;
        while (!ins_ready) begin
            step();
            guard++;
            if (guard > 50) begin
                $display("FAIL ready_timeout actual=0 required=1");
                $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
                $fatal(1, "ready timeout");
            end
        end
        ins_valid = 1; ins_op = op; ins_rx = rx; ins_ry = ry; ins_imm_sel = isel; ins_imm = imm;
        if (push) begin
            model_exec(op, rx, ry, isel, imm, e);
            exp_q.push_back(e);
        end
        step();
        if (hold) begin
            for (int k = 0; k < 3; k++) begin
                ins_op = 3'($urandom_range(0, 7)); ins_rx = 3'($urandom_range(0, 7));
                ins_ry = 3'($urandom_range(0, 7)); ins_imm_sel = 1'($urandom_range(0, 1));
                ins_imm = N'($urandom);
                step();
            end
        end
        ins_valid = 0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0 && !pending_post && ins_ready) break;
            step();
        end
        chk("idle_reached", {31'd0, (exp_q.size() == 0 && !pending_post)}, 32'd1);
    endtask

    task automatic read_reg(input logic [2:0] r, input logic [N-1:0] req, input string name);
        drv_sel = 1; drv_addr = r;
        #1;
        chk(name, 32'(rd_data), 32'(req));
        drv_sel = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; ins_valid = 0; ins_op = '0; ins_rx = '0; ins_ry = '0;
        ins_imm_sel = 0; ins_imm = '0;
        model_reset();
        repeat (3) step();
        reset = 0;
        // reset state
        chk("reset_ready", 32'(ins_ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_flags", {29'd0, flag_z, flag_c, flag_n}, 32'd0);
        for (int i = 0; i < 8; i++) read_reg(3'(i), '0, "reset_reg");

        // directed sequence
        issue(3'd0, 3'd1, 3'd0, 1, 8'hF0, 0, 1);
        issue(3'd0, 3'd2, 3'd0, 1, 8'h20, 0, 1);
        issue(3'd2, 3'd1, 3'd2, 0, 8'h00, 0, 1);
        issue(3'd0, 3'd3, 3'd0, 1, 8'h55, 0, 1);
        issue(3'd3, 3'd3, 3'd0, 1, 8'h55, 0, 1);
        issue(3'd3, 3'd3, 3'd0, 1, 8'h01, 0, 1);
        issue(3'd0, 3'd4, 3'd0, 1, 8'h3C, 0, 1);
        issue(3'd4, 3'd4, 3'd0, 1, 8'h0F, 0, 1);
        issue(3'd1, 3'd4, 3'd0, 1, 8'hA5, 0, 1);
        issue(3'd5, 3'd1, 3'd1, 0, 8'h00, 0, 1);
        issue(3'd6, 3'd2, 3'd3, 1, 8'h77, 0, 1);
        issue(3'd0, 3'd6, 3'd0, 1, 8'h99, 1, 1);
        wait_idle();
        read_reg(3'd1, 8'h10, "dir_r1");
        read_reg(3'd2, 8'h20, "dir_r2");
        read_reg(3'd3, 8'hFF, "dir_r3");
        read_reg(3'd4, 8'h5C, "dir_r4");
        read_reg(3'd6, 8'h99, "dir_r6");
        chk("dir_flags", {29'd0, flag_z, flag_c, flag_n}, {29'd0, 1'b1, 1'b1, 1'b0});

        // reset during EXEC abandons the instruction
        issue(3'd2, 3'd5, 3'd0, 1, 8'h01, 0, 0);
        step();
        reset = 1;
        step();
        reset = 0;
        model_reset();
        chk("abort_ready", 32'(ins_ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        repeat (4) step();
        read_reg(3'd5, '0, "abort_r5");
        read_reg(3'd1, '0, "abort_r1");
        chk("abort_flags", {29'd0, flag_z, flag_c, flag_n}, 32'd0);

        // randomized traffic
        for (int t = 0; t < 300; t++) begin
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), N'($urandom), ($urandom_range(0, 3) == 0), 1);
        end
        wait_idle();
        for (int i = 0; i < 8; i++) read_reg(3'(i), mr[i], "final_reg");
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
